alu_lane_scheduler: RTL and testbench
=====================================

// Module: alu_lane_scheduler
// PURPOSE
//  Round-robin scheduler sharing the four ALU lanes (0=AB arith, 1=LB logic, 2=LSB lshift, 3=RSB rshift)
//  and their RF read/write ports between NREQ micro-op requesters.
//  Buffers requests in per-requester FIFOs and issues up to four non-conflicting ops per cycle.
//  Drives the RF select_a/b/c/r and enable_writing inputs and the ALU *_op_i inputs with registered outputs.
// PARAMETERS
//  NREQ        2   number of requesters (>=1)
//  FIFO_DEPTH  2   entries per requester FIFO (power of 2, >=2)
//  ADDR_W      3   RF register address width
// PORTS
//  clk_i        in   1             clock, rising edge
//  arst_i       in   1             asynchronous reset, active-low
//  flush_i      in   1             synchronous flush: empties FIFOs, clears outputs next edge
//  lane_hold_i  in   4             lane busy externally; no issue to a held lane this cycle
//  req_valid_i  in   NREQ          request valid
//  req_ready_o  out  NREQ          FIFO not full (combinational from FIFO count)
//  req_lane_i   in   NREQx2        target lane
//  req_op_i     in   NREQx2        lane opcode
//  req_ra_i     in   NREQxADDR_W   source A; req_rb_i / req_rc_i / req_rd_i same width: src B, shift count, dest
//  sel_a_o      out  4xADDR_W      RF select_a per lane;  sel_b_o, sel_r_o same shape
//  sel_c_o      out  2xADDR_W      RF select_c for lanes 2,3 (index 0 = lane 2)
//  op_o         out  4x2           AB/LB/LSB/RSB opcode
//  we_o         out  4             RF enable_writing per lane
//  grant_o      out  NREQ          requester issued in the cycle that produced current we_o
// BEHAVIOUR
//  - Reset (arst_i=0, async): FIFOs empty, rr_ptr=0, all outputs 0; req_ready_o=1 after release.
//  - Accept on req_valid_i&req_ready_o at an edge; entry is eligible from the next cycle (no bypass).
//  - Arbitration cycle T: visit requesters from rr_ptr upward mod NREQ; grant the FIFO head if:
//    lane not held, lane not already granted in T, rd differs from every rd granted in T.
//    Requester gets at most one grant per cycle; granted heads pop at end of T.
//  - rr_ptr <= (first granted index + 1) mod NREQ; unchanged if no grant in T.
//  - Issue registered: in T+1, for granted lane L: we_o[L]=1, sel_*_o[L], op_o[L] = head fields;
//    lanes 0,1 ignore rc. Non-issuing lanes: we_o=0, sel/op=0. Pulse lasts exactly one cycle.
//  - Latency: handshake edge -> we_o high = 2 cycles minimum; throughput 1 op/requester/cycle.
//  - FIFO full: req_ready_o=0; a pop in the same cycle does not re-open ready until next cycle.
//  - Simultaneous push+pop on full/non-empty FIFO: both occur, count unchanged.
//  - flush_i (priority over push/grant): FIFOs emptied, rr_ptr=0, outputs 0 at next edge.
//  - arst_i asserted mid-operation: pending ops dropped, no we_o pulse emitted.
// CONFIGURATION
//  ALU_SCHED_STATS_EN defined: adds stall_cnt_o out NREQx16: per requester, +1 each cycle its
//    FIFO head is valid and not granted; saturates at 16'hFFFF; cleared by reset and flush_i.
//  Undefined: port and counters absent; scheduling behaviour identical.
// TESTING
//  1. req0 lane0 op=1 ra=1 rb=2 rd=3 at T -> T+2: we_o=4'b0001, sel_a_o[0]=1, sel_b_o[0]=2,
//     sel_r_o[0]=3, op_o[0]=1, grant_o=2'b01; T+3: we_o=0.
//  2. req0,req1 both lane2 (rd 1,2) every cycle, rr_ptr=0 -> grants alternate 01,10,01,...
//  3. req0 lane0 rd=5 + req1 lane3 rd=5 same cycle -> serialised over 2 cycles;
//     rd=5/rd=6 -> same cycle we_o=4'b1001, sel_c_o[1]=req1 rc.
//  4. lane_hold_i=4'b0001, push 3 lane0 ops on req0 -> req_ready_o[0]=0 after 2 accepts;
//     release hold -> we_o[0] pulses on 2 consecutive cycles.
//  5. flush_i with 2 entries queued -> no we_o afterwards, req_ready_o=1 next cycle;
//     arst_i low mid-burst -> all outputs 0 immediately.
//  6. ALU_SCHED_STATS_EN: req1 blocked by req0 on same lane for 3 cycles -> stall_cnt_o[1]=3.

Source files
------------

// File: rtl/alu_lane_scheduler.sv
// alu_lane_scheduler: round-robin issue of buffered micro-ops onto the four
// ALU lanes (0=AB arith, 1=LB logic, 2=LSB lshift, 3=RSB rshift).
// Each requester owns a small FIFO. Every cycle the FIFO heads are visited in
// round-robin order, and up to four heads are granted. Two granted heads may
// not share a lane or a destination register. The RF selects, write enables
// and opcodes for the granted heads are registered and appear one cycle later.
// Optional build macro ALU_SCHED_STATS_EN adds per-requester stall counters
// on port stall_cnt_o.
module alu_lane_scheduler #(
    parameter int NREQ       = 2,
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 3
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     flush_i,
    input  logic [3:0]               lane_hold_i,
    input  logic [NREQ-1:0]          req_valid_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic [2*NREQ-1:0]        req_lane_i,
    input  logic [2*NREQ-1:0]        req_op_i,
    input  logic [ADDR_W*NREQ-1:0]   req_ra_i,
    input  logic [ADDR_W*NREQ-1:0]   req_rb_i,
    input  logic [ADDR_W*NREQ-1:0]   req_rc_i,
    input  logic [ADDR_W*NREQ-1:0]   req_rd_i,
    output logic [4*ADDR_W-1:0]      sel_a_o,
    output logic [4*ADDR_W-1:0]      sel_b_o,
    output logic [4*ADDR_W-1:0]      sel_r_o,
    output logic [2*ADDR_W-1:0]      sel_c_o,
    output logic [7:0]               op_o,
    output logic [3:0]               we_o,
    output logic [NREQ-1:0]          grant_o
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [NREQ*16-1:0]       stall_cnt_o
`endif
);

    // Entry layout, MSB to LSB: {lane, op, ra, rb, rc, rd}.
    localparam int EW       = 4 + 4*ADDR_W;
    localparam int RD_LSB   = 0;
    localparam int RC_LSB   = ADDR_W;
    localparam int RB_LSB   = 2*ADDR_W;
    localparam int RA_LSB   = 3*ADDR_W;
    localparam int OP_LSB   = 4*ADDR_W;
    localparam int LANE_LSB = 4*ADDR_W + 2;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int RR_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NRD      = 1 << ADDR_W;

    logic [NREQ-1:0][EW-1:0]    head_entry;
    logic [NREQ-1:0]            head_valid;
    logic [NREQ-1:0]            push;
    logic [NREQ-1:0]            grant_next;
    logic [NREQ-1:0]            grant_reg;
    logic [RR_W-1:0]            rr_ptr_reg;
    logic [RR_W-1:0]            rr_ptr_next;

    logic [3:0]                 we_next, we_reg;
    logic [3:0][ADDR_W-1:0]     sel_a_next, sel_a_reg;
    logic [3:0][ADDR_W-1:0]     sel_b_next, sel_b_reg;
    logic [3:0][ADDR_W-1:0]     sel_r_next, sel_r_reg;
    logic [1:0][ADDR_W-1:0]     sel_c_next, sel_c_reg;
    logic [3:0][1:0]            op_next, op_reg;

    logic [3:0]                 arb_lane_used;
    logic [NRD-1:0]             arb_rd_used;
    logic                       arb_found;
    int                         arb_sum;
    logic [RR_W-1:0]            arb_idx;
    logic [EW-1:0]              arb_entry;
    logic [1:0]                 arb_lane;
    logic [ADDR_W-1:0]          arb_rd;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic [EW-1:0]    mem [FIFO_DEPTH];
        logic [PTR_W-1:0] wr_ptr_reg;
        logic [PTR_W-1:0] rd_ptr_reg;
        logic [CNT_W-1:0] count_reg;
        logic [EW-1:0]    in_entry;

        assign in_entry = {req_lane_i[gi*2 +: 2], req_op_i[gi*2 +: 2],
                           req_ra_i[gi*ADDR_W +: ADDR_W], req_rb_i[gi*ADDR_W +: ADDR_W],
                           req_rc_i[gi*ADDR_W +: ADDR_W], req_rd_i[gi*ADDR_W +: ADDR_W]};
        // Ready depends only on the stored count, so a same-cycle pop cannot reopen it.
        assign req_ready_o[gi] = (count_reg != CNT_W'(FIFO_DEPTH));
        assign push[gi]        = req_valid_i[gi] & req_ready_o[gi] & ~flush_i;
        assign head_valid[gi]  = (count_reg != '0);
        assign head_entry[gi]  = mem[rd_ptr_reg];

        // Entry storage; no reset needed since the count guards validity.
        always_ff @(posedge clk_i) begin
            if (push[gi]) begin
                mem[wr_ptr_reg] <= in_entry;
            end
        end

        // FIFO pointers and occupancy; a grant is the pop.
        always_ff @(posedge clk_i or negedge arst_i) begin
            if (!arst_i) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else if (flush_i) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push[gi]) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (grant_next[gi]) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                case ({push[gi], grant_next[gi]})
                    2'b10:   count_reg <= count_reg + 1'b1;
                    2'b01:   count_reg <= count_reg - 1'b1;
                    default: count_reg <= count_reg;
                endcase
            end
        end

`ifdef ALU_SCHED_STATS_EN
        logic [15:0] stall_cnt_reg;

        // Count cycles where this requester had a head waiting but lost arbitration.
        always_ff @(posedge clk_i or negedge arst_i) begin
            if (!arst_i) begin
                stall_cnt_reg <= '0;
            end else if (flush_i) begin
                stall_cnt_reg <= '0;
            end else if (head_valid[gi] && !grant_next[gi] && stall_cnt_reg != 16'hFFFF) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end

        assign stall_cnt_o[gi*16 +: 16] = stall_cnt_reg;
`endif
    end

    // Round-robin arbitration over FIFO heads with lane and destination conflict checks.
    always_comb begin
        grant_next    = '0;
        we_next       = '0;
        sel_a_next    = '0;
        sel_b_next    = '0;
        sel_r_next    = '0;
        sel_c_next    = '0;
        op_next       = '0;
        rr_ptr_next   = rr_ptr_reg;
        arb_lane_used = '0;
        arb_rd_used   = '0;
        arb_found     = 1'b0;
        arb_sum       = 0;
        arb_idx       = '0;
        arb_entry     = '0;
        arb_lane      = '0;
        arb_rd        = '0;
        for (int k = 0; k < NREQ; k++) begin
            arb_sum = int'(rr_ptr_reg) + k;
            if (arb_sum >= NREQ) begin
                arb_sum = arb_sum - NREQ;
            end
            arb_idx   = RR_W'(arb_sum);
            arb_entry = head_entry[arb_idx];
            arb_lane  = arb_entry[LANE_LSB +: 2];
            arb_rd    = arb_entry[RD_LSB +: ADDR_W];
            if (head_valid[arb_idx] && !lane_hold_i[arb_lane] &&
                !arb_lane_used[arb_lane] && !arb_rd_used[arb_rd]) begin
                grant_next[arb_idx]     = 1'b1;
                arb_lane_used[arb_lane] = 1'b1;
                arb_rd_used[arb_rd]     = 1'b1;
                we_next[arb_lane]       = 1'b1;
                sel_a_next[arb_lane]    = arb_entry[RA_LSB +: ADDR_W];
                sel_b_next[arb_lane]    = arb_entry[RB_LSB +: ADDR_W];
                sel_r_next[arb_lane]    = arb_entry[RD_LSB +: ADDR_W];
                op_next[arb_lane]       = arb_entry[OP_LSB +: 2];
                // Only the shifter lanes (2,3) carry a shift-count register.
                if (arb_lane[1]) begin
                    sel_c_next[arb_lane[0]] = arb_entry[RC_LSB +: ADDR_W];
                end
                if (!arb_found) begin
                    arb_found   = 1'b1;
                    rr_ptr_next = (arb_sum == NREQ - 1) ? '0 : RR_W'(arb_sum + 1);
                end
            end
        end
    end

    // Registered issue: one-cycle pulse of selects/enables for the lanes granted last cycle.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            rr_ptr_reg <= '0;
            we_reg     <= '0;
            sel_a_reg  <= '0;
            sel_b_reg  <= '0;
            sel_r_reg  <= '0;
            sel_c_reg  <= '0;
            op_reg     <= '0;
            grant_reg  <= '0;
        end else if (flush_i) begin
            rr_ptr_reg <= '0;
            we_reg     <= '0;
            sel_a_reg  <= '0;
            sel_b_reg  <= '0;
            sel_r_reg  <= '0;
            sel_c_reg  <= '0;
            op_reg     <= '0;
            grant_reg  <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            we_reg     <= we_next;
            sel_a_reg  <= sel_a_next;
            sel_b_reg  <= sel_b_next;
            sel_r_reg  <= sel_r_next;
            sel_c_reg  <= sel_c_next;
            op_reg     <= op_next;
            grant_reg  <= grant_next;
        end
    end

    assign we_o    = we_reg;
    assign sel_a_o = sel_a_reg;
    assign sel_b_o = sel_b_reg;
    assign sel_r_o = sel_r_reg;
    assign sel_c_o = sel_c_reg;
    assign op_o    = op_reg;
    assign grant_o = grant_reg;

endmodule

// File: tb/tb_alu_lane_scheduler.sv
// Testbench for alu_lane_scheduler: directed scenarios plus randomized traffic,
// every cycle checked against a queue-based reference model.
module tb_alu_lane_scheduler;

    localparam int NREQ  = 2;
    localparam int DEPTH = 2;
    localparam int AW    = 3;

    logic                 clk = 1'b0;
    logic                 arst_i = 1'b0;
    logic                 flush_i = 1'b0;
    logic [3:0]           lane_hold = '0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_lane = '0;
    logic [2*NREQ-1:0]    req_op = '0;
    logic [AW*NREQ-1:0]   req_ra = '0;
    logic [AW*NREQ-1:0]   req_rb = '0;
    logic [AW*NREQ-1:0]   req_rc = '0;
    logic [AW*NREQ-1:0]   req_rd = '0;
    logic [4*AW-1:0]      sel_a, sel_b, sel_r;
    logic [2*AW-1:0]      sel_c;
    logic [7:0]           op;
    logic [3:0]           we;
    logic [NREQ-1:0]      grant;
`ifdef ALU_SCHED_STATS_EN
    logic [NREQ*16-1:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    alu_lane_scheduler #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk_i       (clk),
        .arst_i      (arst_i),
        .flush_i     (flush_i),
        .lane_hold_i (lane_hold),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_lane_i  (req_lane),
        .req_op_i    (req_op),
        .req_ra_i    (req_ra),
        .req_rb_i    (req_rb),
        .req_rc_i    (req_rc),
        .req_rd_i    (req_rd),
        .sel_a_o     (sel_a),
        .sel_b_o     (sel_b),
        .sel_r_o     (sel_r),
        .sel_c_o     (sel_c),
        .op_o        (op),
        .we_o        (we),
        .grant_o     (grant)
`ifdef ALU_SCHED_STATS_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    typedef struct packed {
        logic [1:0]    lane;
        logic [1:0]    opc;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [AW-1:0] rc;
        logic [AW-1:0] rd;
    } op_t;

    // Reference model state
    op_t             q [NREQ][$];
    int              rr;
    logic [3:0]      exp_we;
    logic [4*AW-1:0] exp_sel_a, exp_sel_b, exp_sel_r;
    logic [2*AW-1:0] exp_sel_c;
    logic [7:0]      exp_op;
    logic [NREQ-1:0] exp_grant;
    int              stall_m [NREQ];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREQ; r++) begin
            q[r].delete();
            stall_m[r] = 0;
        end
        rr        = 0;
        exp_we    = '0;
        exp_sel_a = '0;
        exp_sel_b = '0;
        exp_sel_r = '0;
        exp_sel_c = '0;
        exp_op    = '0;
        exp_grant = '0;
    endtask

    // One clock edge of the reference model: arbitrate on pre-edge queues, pop, then push.
    task automatic model_edge();
        logic [NREQ-1:0] acc;
        logic [3:0]      lane_taken;
        logic [7:0]      rd_taken;
        int              first;
        int              r;
        op_t             e;
        for (int i = 0; i < NREQ; i++) acc[i] = req_valid[i] && (q[i].size() < DEPTH);
        if (flush_i) begin
            model_clear();
            return;
        end
        exp_we = '0; exp_sel_a = '0; exp_sel_b = '0; exp_sel_r = '0;
        exp_sel_c = '0; exp_op = '0; exp_grant = '0;
        lane_taken = '0;
        rd_taken   = '0;
        first      = -1;
        for (int k = 0; k < NREQ; k++) begin
            r = (rr + k) % NREQ;
            if (q[r].size() > 0) begin
                e = q[r][0];
                if (!lane_hold[e.lane] && !lane_taken[e.lane] && !rd_taken[e.rd]) begin
                    lane_taken[e.lane] = 1'b1;
                    rd_taken[e.rd]     = 1'b1;
                    exp_grant[r]       = 1'b1;
                    exp_we[e.lane]     = 1'b1;
                    exp_sel_a[int'(e.lane)*AW +: AW] = e.ra;
                    exp_sel_b[int'(e.lane)*AW +: AW] = e.rb;
                    exp_sel_r[int'(e.lane)*AW +: AW] = e.rd;
                    exp_op[int'(e.lane)*2 +: 2]      = e.opc;
                    if (e.lane >= 2) exp_sel_c[(int'(e.lane) - 2)*AW +: AW] = e.rc;
                    if (first < 0) first = r;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (exp_grant[i]) void'(q[i].pop_front());
            else if (q[i].size() > 0 && stall_m[i] < 65535) stall_m[i]++;
        end
        if (first >= 0) rr = (first + 1) % NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                e.lane = req_lane[i*2 +: 2];
                e.opc  = req_op[i*2 +: 2];
                e.ra   = req_ra[i*AW +: AW];
                e.rb   = req_rb[i*AW +: AW];
                e.rc   = req_rc[i*AW +: AW];
                e.rd   = req_rd[i*AW +: AW];
                q[i].push_back(e);
            end
        end
    endtask

    // Advance one clock: check ready before the edge, then all registered outputs after it.
    task automatic cycle();
        logic [NREQ-1:0] exp_ready;
        #1;
        for (int i = 0; i < NREQ; i++) exp_ready[i] = (q[i].size() < DEPTH);
        check("ready", req_ready, exp_ready);
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("we", we, exp_we);
        check("grant", grant, exp_grant);
        check("sel_a", sel_a, exp_sel_a);
        check("sel_b", sel_b, exp_sel_b);
        check("sel_r", sel_r, exp_sel_r);
        check("sel_c", sel_c, exp_sel_c);
        check("op", op, exp_op);
`ifdef ALU_SCHED_STATS_EN
        for (int i = 0; i < NREQ; i++) check("stall_cnt", stall_cnt[i*16 +: 16], stall_m[i]);
`endif
        if (we != 0) $display("cycle %0d issue grant=%b we=%b op=%h", cyc, grant, we, op);
    endtask

    task automatic set_req(input int r, input bit v, input int lane, input int opc,
                           input int ra, input int rb, input int rc, input int rd);
        req_valid[r]         = v;
        req_lane[r*2 +: 2]   = 2'(lane);
        req_op[r*2 +: 2]     = 2'(opc);
        req_ra[r*AW +: AW]   = AW'(ra);
        req_rb[r*AW +: AW]   = AW'(rb);
        req_rc[r*AW +: AW]   = AW'(rc);
        req_rd[r*AW +: AW]   = AW'(rd);
    endtask

    task automatic do_flush();
        req_valid = '0;
        flush_i   = 1'b1;
        cycle();
        flush_i   = 1'b0;
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        arst_i = 1'b1;
        // Reset state
        check("rst_we", we, 4'b0000);
        check("rst_grant", grant, '0);
        check("rst_sel_a", sel_a, '0);
        check("rst_op", op, '0);
        check("rst_ready", req_ready, 2'b11);

        // Single op: 2-cycle latency, one-cycle pulse
        set_req(0, 1, 0, 1, 1, 2, 0, 3);
        cycle();
        req_valid = '0;
        cycle();
        check("t1_we", we, 4'b0001);
        check("t1_sel_a0", sel_a[AW-1:0], 1);
        check("t1_sel_b0", sel_b[AW-1:0], 2);
        check("t1_sel_r0", sel_r[AW-1:0], 3);
        check("t1_op0", op[1:0], 1);
        check("t1_grant", grant, 2'b01);
        cycle();
        check("t1_we_off", we, 4'b0000);

        // Same lane, both requesters: alternating grants
        do_flush();
        set_req(0, 1, 2, 0, 1, 2, 3, 1);
        set_req(1, 1, 2, 0, 4, 5, 6, 2);
        cycle();
        cycle();
        check("t2_g0", grant, 2'b01);
        cycle();
        check("t2_g1", grant, 2'b10);
        cycle();
        check("t2_g2", grant, 2'b01);
        repeat (4) cycle();
        req_valid = '0;
        repeat (6) cycle();

        // Destination conflict serialises; distinct destinations co-issue
        do_flush();
        set_req(0, 1, 0, 0, 1, 1, 0, 5);
        set_req(1, 1, 3, 2, 2, 3, 4, 5);
        cycle();
        req_valid = '0;
        cycle();
        check("t3_we_a", we, 4'b0001);
        cycle();
        check("t3_we_b", we, 4'b1000);
        set_req(0, 1, 0, 0, 1, 1, 0, 5);
        set_req(1, 1, 3, 2, 2, 3, 4, 6);
        cycle();
        req_valid = '0;
        cycle();
        check("t3_we_c", we, 4'b1001);
        check("t3_sel_c1", sel_c[2*AW-1:AW], 4);
        cycle();

        // Held lane fills the FIFO; release drains on consecutive cycles
        do_flush();
        lane_hold = 4'b0001;
        set_req(0, 1, 0, 3, 1, 1, 1, 7);
        cycle();
        cycle();
        check("t4_full", req_ready[0], 1'b0);
        cycle();
        req_valid = '0;
        lane_hold = 4'b0000;
        cycle();
        check("t4_we1", we[0], 1'b1);
        cycle();
        check("t4_we2", we[0], 1'b1);
        cycle();
        check("t4_we3", we, 4'b0000);

        // Flush with queued entries
        lane_hold = 4'b1111;
        set_req(1, 1, 1, 2, 3, 4, 5, 6);
        cycle();
        cycle();
        req_valid = '0;
        lane_hold = 4'b0000;
        flush_i   = 1'b1;
        cycle();
        flush_i   = 1'b0;
        repeat (3) cycle();
        check("t5_we", we, 4'b0000);

        // Asynchronous reset mid-burst
        set_req(0, 1, 0, 1, 1, 2, 3, 4);
        set_req(1, 1, 1, 2, 5, 6, 7, 2);
        repeat (3) cycle();
        arst_i = 1'b0;
        #1;
        check("arst_we", we, 4'b0000);
        check("arst_grant", grant, '0);
        check("arst_sel_a", sel_a, '0);
        check("arst_op", op, '0);
        @(posedge clk);
        #1;
        arst_i    = 1'b1;
        req_valid = '0;
        model_clear();
        check("arst_ready", req_ready, 2'b11);
        repeat (2) cycle();

`ifdef ALU_SCHED_STATS_EN
        // Requester 1 blocked behind requester 0 on the same lane
        do_flush();
        set_req(0, 1, 1, 0, 1, 1, 1, 1);
        set_req(1, 1, 1, 0, 2, 2, 2, 2);
        repeat (4) cycle();
        req_valid = '0;
        repeat (6) cycle();
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < NREQ; r++) begin
                set_req(r, ($urandom % 4) != 0, $urandom % 4, $urandom % 4,
                        $urandom % 8, $urandom % 8, $urandom % 8, $urandom % 3);
            end
            lane_hold = (($urandom % 6) == 0) ? 4'($urandom) : 4'b0000;
            flush_i   = (($urandom % 40) == 0);
            cycle();
        end
        flush_i   = 1'b0;
        lane_hold = '0;
        req_valid = '0;
        repeat (6) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
